// File: rtl/mips_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit.
//   MD_*    : 3-bit op codes presented on muldiv_unit.op
//   ST_*    : FSM state encodings used by muldiv_unit
package mips_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the shared multiply/divide datapath (combinational).
//   acc_i     : 2*WIDTH+1 accumulator
//               multiply: {partial product (WIDTH+1), remaining multiplier (WIDTH)}
//               divide  : {partial remainder (WIDTH+1), dividend/quotient (WIDTH)}
//   operand_i : multiplicand (multiply) or divisor (divide), both magnitudes
//   is_div_i  : selects restoring-divide step instead of shift-add step
//   acc_o     : accumulator after this step (divide leaves bit 0 clear)
//   q_bit_o   : quotient bit of this step; the caller ORs it into bit 0
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0] acc_i,
  input  logic [WIDTH-1:0] operand_i,
  input  logic             is_div_i,
  output logic [2*WIDTH:0] acc_o,
  output logic             q_bit_o
);

  logic [WIDTH:0]   sum;
  logic [2*WIDTH:0] sh;
  logic [WIDTH:0]   upper;
  logic [WIDTH:0]   diff;

  always_comb begin
    // Multiply: conditionally add multiplicand into the upper half, then shift right.
    sum   = acc_i[2*WIDTH:WIDTH] + (acc_i[0] ? {1'b0, operand_i} : '0);
    // Divide: shift left one, trial-subtract divisor from the widened upper half.
    sh    = {acc_i[2*WIDTH-1:0], 1'b0};
    upper = sh[2*WIDTH:WIDTH];
    diff  = upper - {1'b0, operand_i};
    acc_o   = '0;
    q_bit_o = 1'b0;
    if (is_div_i) begin
      // A zero divisor always "fits", giving an all-ones quotient and remainder = dividend.
      q_bit_o = (upper >= {1'b0, operand_i});
      acc_o   = {(q_bit_o ? diff : upper), sh[WIDTH-1:0]};
    end else begin
      acc_o = {1'b0, sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO register pair.
//   clk, reset (async, active-high)
//   start, op[2:0], a, b : request strobe, op code, rs/rt operands
//   abort                : pipeline flush, cancels any in-flight operation
//   busy                 : operation in flight (33 cycles for mul/div)
//   done                 : one-cycle pulse after HI/LO are written by mul/div
//   hi, lo               : architectural HI/LO registers
//   div_zero             : sticky divide-by-zero flag, cleared by next accepted mul/div
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d, sgn_q, sgn_d, sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d, dz_q, dz_d;

  logic               is_md_op, op_div, op_sgn;
  logic signed [WIDTH-1:0] a_s, b_s;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH:0]   step_acc;
  logic               step_q;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_i     (acc_q),
    .operand_i (opnd_q),
    .is_div_i  (is_div_q),
    .acc_o     (step_acc),
    .q_bit_o   (step_q)
  );

  always_comb begin
    is_md_op = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    op_div   = (op == MD_DIV) || (op == MD_DIVU);
    op_sgn   = (op == MD_MULT) || (op == MD_DIV);
    a_s      = a;
    b_s      = b;
    a_neg    = op_sgn && (a_s < 0);
    b_neg    = op_sgn && (b_s < 0);
    // Negating the most negative value wraps to itself, which is its correct unsigned magnitude.
    a_mag    = neg_w(a, a_neg);
    b_mag    = neg_w(b, b_neg);

    prod = neg_2w(acc_q[2*WIDTH-1:0], sgn_q && (sa_q ^ sb_q));
    quo  = neg_w(acc_q[WIDTH-1:0], sgn_q && (sa_q ^ sb_q));
    rem  = neg_w(acc_q[2*WIDTH-1:WIDTH], sgn_q && sa_q);

    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    sgn_d    = sgn_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;
    done_d   = 1'b0;

    if (abort) begin
      // Flush wins over everything, including a same-cycle request.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (op == MD_MTHI) begin
              hi_d = a;
            end else if (op == MD_MTLO) begin
              lo_d = a;
            end else if (is_md_op) begin
              acc_d    = {{(WIDTH+1){1'b0}}, (op_div ? a_mag : b_mag)};
              opnd_d   = op_div ? b_mag : a_mag;
              is_div_d = op_div;
              sgn_d    = op_sgn;
              sa_d     = a_neg;
              sb_d     = b_neg;
              dz_d     = op_div && (b == '0);
              cnt_d    = '0;
              state_d  = ST_CALC;
            end
          end
        end
        ST_CALC: begin
          acc_d = step_acc | {{(2*WIDTH){1'b0}}, step_q};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = ST_FIX;
          end
        end
        ST_FIX: begin
          if (is_div_q) begin
            lo_d = quo;
            hi_d = rem;
          end else begin
            {hi_d, lo_d} = prod;
          end
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control and architectural state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  // Iteration datapath; only meaningful while the FSM is out of IDLE
  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    opnd_q   <= opnd_d;
    is_div_q <= is_div_d;
    sgn_q    <= sgn_d;
    sa_q     <= sa_d;
    sb_q     <= sb_d;
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam int W = 32;
  localparam logic [2:0] OP_MULT = 3'b000, OP_MULTU = 3'b001, OP_DIV = 3'b010,
                         OP_DIVU = 3'b011, OP_MTHI = 3'b100, OP_MTLO = 3'b101, OP_NOP = 3'b110;

  logic         clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0;
  logic [2:0]   op = OP_NOP;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .abort(abort),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Scoreboard monitor: every done pulse consumes one expected HI/LO/div_zero triple.
  always @(negedge clk) begin
    if (!reset && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", W'(done), '0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_hi", hi, e.hi);
        check("sb_lo", lo, e.lo);
        check("sb_div_zero", W'(div_zero), W'(e.dz));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
  endtask

  task automatic wait_idle(input string name, input int exp_cycles);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, W'(n), W'(exp_cycles));
  endtask

  task automatic run_md(input string name, input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] eh, input logic [W-1:0] el,
                        input logic edz);
    exp_t e;
    e.hi = eh; e.lo = el; e.dz = edz;
    exp_q.push_back(e);
    issue(o, x, y);
    wait_idle({name, "_busy_cycles"}, 33);
  endtask

  initial begin
    int dn;
    exp_t e;

    // Asynchronous reset, checked before any clock edge
    #2 reset = 1'b1;
    #2;
    check("rst_hi", hi, '0);
    check("rst_lo", lo, '0);
    check("rst_busy", W'(busy), '0);
    check("rst_done", W'(done), '0);
    check("rst_div_zero", W'(div_zero), '0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_md("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_md("mult_neg",  OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run_md("div_neg_a", OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_md("div_neg_b", OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
    run_md("divu_zero", OP_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1);
    run_md("multu_2x3", OP_MULTU, 32'd2,        32'd3,        32'd0,        32'd6,        1'b0);
    run_md("div_minint", OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0);

    // MTHI / MTLO: single-edge writes, never busy
    issue(OP_MTHI, 32'h12345678, 32'd0);
    check("mthi_hi", hi, 32'h12345678);
    check("mthi_lo_kept", lo, 32'h80000000);
    check("mthi_busy", W'(busy), '0);
    issue(OP_MTLO, 32'h9ABCDEF0, 32'd0);
    check("mtlo_lo", lo, 32'h9ABCDEF0);
    check("mtlo_busy", W'(busy), '0);
    check("mtlo_done", W'(done), '0);

    // abort together with a request in IDLE drops the request
    abort = 1'b1;
    issue(OP_MTHI, 32'hCAFEF00D, 32'd0);
    abort = 1'b0;
    check("abort_start_hi", hi, 32'h12345678);

    // MTLO issued mid-multiply is ignored; HI/LO hold until the FIX edge
    e.hi = 32'd0; e.lo = 32'd30; e.dz = 1'b0;
    exp_q.push_back(e);
    issue(OP_MULTU, 32'd5, 32'd6);
    repeat (4) @(negedge clk);
    issue(OP_MTLO, 32'hDEADBEEF, 32'd0);
    check("midop_lo_held", lo, 32'h9ABCDEF0);
    check("midop_hi_held", hi, 32'h12345678);
    wait_idle("midop_busy_cycles", 28);

    // Abort a DIVU partway through: no done, HI/LO unchanged
    issue(OP_DIVU, 32'd50, 32'd7);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", W'(busy), '0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd30);
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("abort_no_done", W'(dn), '0);

    // Set div_zero and nonzero HI/LO, then reset asynchronously mid-CALC
    run_md("divu9_zero", OP_DIVU, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF, 1'b1);
    issue(OP_DIVU, 32'd9, 32'd0);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", W'(busy), '0);
    check("midrst_hi", hi, '0);
    check("midrst_lo", lo, '0);
    check("midrst_div_zero", W'(div_zero), '0);
    check("midrst_done", W'(done), '0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_busy", W'(busy), '0);
    check("scoreboard_drained", W'(exp_q.size()), '0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
